hdc_modality_fuser: RTL

- Parametrised fold-serial fuser for the sensor-fusion pipeline. Sits between the spatial encoder and the temporal encoder.
- Accepts NUM_MODALITIES folded spatial hypervectors per sample, one FOLD_WIDTH slice per handshake.
- Keeps a per-bit modality vote count and emits one HV_DIMENSION-wide bitwise-majority hypervector per sample.
- Generalises the fixed three-modality fuser to any modality count, fold count and dimension, and adds flush and configurable tie handling.

---
 rtl/hdc_modality_fuser.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hdc_modality_fuser.sv
// Fold-serial bitwise-majority fuser: NUM_MODALITIES folded hypervectors in, one fused hypervector out.
// Optional FUSER_TIE_MODALITY0_EN: even-count ties take modality 0's bit instead of 0.
module hdc_modality_fuser #(
    parameter int unsigned HV_DIMENSION    = 2000,
    parameter int unsigned NUM_FOLDS       = 8,
    parameter int unsigned NUM_MODALITIES  = 3,
    parameter int unsigned FOLD_WIDTH      = HV_DIMENSION / NUM_FOLDS,
    parameter int unsigned NUM_FOLDS_WIDTH = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
    parameter int unsigned CNT_WIDTH       = $clog2(NUM_MODALITIES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       hvin_valid,
    output logic                       hvin_ready,
    input  logic [FOLD_WIDTH-1:0]      hvin,
    output logic                       hvout_valid,
    input  logic                       hvout_ready,
    output logic [HV_DIMENSION-1:0]    hvout,
    output logic [NUM_FOLDS_WIDTH-1:0] fold_counter,
    output logic                       busy
);

    localparam int unsigned MOD_WIDTH = (NUM_MODALITIES > 1) ? $clog2(NUM_MODALITIES) : 1;
    localparam int unsigned HALF      = NUM_MODALITIES / 2;
    localparam bit          EVEN      = (NUM_MODALITIES % 2) == 0;

    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_OUTPUT = 1'b1;

    logic [0:0]                state;
    logic [0:0]                state_next;
    logic [CNT_WIDTH-1:0]      cnt     [HV_DIMENSION];
    logic [CNT_WIDTH-1:0]      cnt_sum [HV_DIMENSION];
    logic [MOD_WIDTH-1:0]      mod_counter;
    logic [HV_DIMENSION-1:0]   majority;
    logic [HV_DIMENSION-1:0]   tie_bits;
    logic                      accept;
    logic                      fold_last;
    logic                      final_accept;
    logic                      flush_accum;

    assign hvin_ready   = (state == ST_ACCUM) & ~flush;
    assign accept       = hvin_valid & hvin_ready;
    assign flush_accum  = flush & (state == ST_ACCUM);
    assign fold_last    = fold_counter == NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
    assign final_accept = accept & fold_last & (mod_counter == MOD_WIDTH'(NUM_MODALITIES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_ACCUM) begin
            if (final_accept) state_next = ST_OUTPUT;
        end else begin
            if (hvout_ready) state_next = ST_ACCUM;
        end
    end

    // Vote counts including the slice accepted this cycle, and the resulting majority.
    always_comb begin
        for (int unsigned f = 0; f < NUM_FOLDS; f++) begin
            for (int unsigned i = 0; i < FOLD_WIDTH; i++) begin
                cnt_sum[f*FOLD_WIDTH+i] = cnt[f*FOLD_WIDTH+i] + CNT_WIDTH'(
                    (accept && (fold_counter == NUM_FOLDS_WIDTH'(f))) ? hvin[i] : 1'b0);
            end
        end
        majority = '0;
        for (int unsigned b = 0; b < HV_DIMENSION; b++) begin
            if (cnt_sum[b] > CNT_WIDTH'(HALF))
                majority[b] = 1'b1;
            else if (EVEN && (cnt_sum[b] == CNT_WIDTH'(HALF)))
                majority[b] = tie_bits[b];
        end
    end

`ifdef FUSER_TIE_MODALITY0_EN
    logic [HV_DIMENSION-1:0] m0_copy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_copy <= '0;
        end else if (final_accept || flush_accum) begin
            m0_copy <= '0;
        end else if (accept && (mod_counter == '0)) begin
            for (int unsigned f = 0; f < NUM_FOLDS; f++) begin
                if (fold_counter == NUM_FOLDS_WIDTH'(f))
                    m0_copy[f*FOLD_WIDTH +: FOLD_WIDTH] <= hvin;
            end
        end
    end

    assign tie_bits = m0_copy;
`else
    assign tie_bits = '0;
`endif

    // Vote counters, fold/modality position and the registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < HV_DIMENSION; b++) cnt[b] <= '0;
            fold_counter <= '0;
            mod_counter  <= '0;
            busy         <= 1'b0;
            hvout        <= '0;
            hvout_valid  <= 1'b0;
        end else begin
            if (final_accept) begin
                for (int unsigned b = 0; b < HV_DIMENSION; b++) cnt[b] <= '0;
                fold_counter <= '0;
                mod_counter  <= '0;
                busy         <= 1'b0;
                hvout        <= majority;
                hvout_valid  <= 1'b1;
            end else if (accept) begin
                cnt  <= cnt_sum;
                busy <= 1'b1;
                if (fold_last) begin
                    fold_counter <= '0;
                    mod_counter  <= mod_counter + MOD_WIDTH'(1);
                end else begin
                    fold_counter <= fold_counter + NUM_FOLDS_WIDTH'(1);
                end
            end else if (flush_accum) begin
                for (int unsigned b = 0; b < HV_DIMENSION; b++) cnt[b] <= '0;
                fold_counter <= '0;
                mod_counter  <= '0;
                busy         <= 1'b0;
            end else if (hvout_valid && hvout_ready) begin
                hvout_valid <= 1'b0;
            end
        end
    end

endmodule
